fifo_bank_in: RTL and testbench
===============================

// Module: fifo_bank_in
// PURPOSE
//  Ingress buffering stage feeding the round-robin arbiter. Four independent lanes (P0..P3)
//  each buffer 12-bit words from the upstream source. The arbiter sees one muxed read port:
//  it pops one lane via one-hot pop[3:0] and samples fifo_out the next cycle. Per-lane
//  empty/almost_full flags go to the arbiter and the source respectively.
// PARAMETERS
//  DATA_W  12  word width (matches arbiter fifo_out)
//  DEPTH   8   words per lane; power of 2, >=4
//  AF_LVL  6   almost_full[i]=1 when count[i] >= AF_LVL; 1 <= AF_LVL <= DEPTH
// PORTS
//  clk          in   1              single clock, rising edge
//  reset        in   1              asynchronous, active-high
//  push         in   4              per-lane write strobe from source
//  data_in      in   4*DATA_W       lane i word on data_in[i*DATA_W +: DATA_W]
//  pop          in   4              one-hot read strobe from arbiter
//  fifo_out     out  DATA_W         registered word popped last cycle
//  valid_out    out  1              fifo_out holds a word popped on the previous edge
//  empty        out  4              empty[i]=1 when count[i]==0
//  almost_full  out  4              almost_full[i]=1 when count[i] >= AF_LVL
//  err          out  4              sticky per-lane error (FIFO_ERR_EN only; else 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers/counts=0, fifo_out=0, valid_out=0,
//    empty=4'b1111, almost_full=0, err=0. Storage not reset.
//  - Flags are pure functions of registered count[i]: valid the cycle after the causing edge.
//  - Write: push[i] & count[i]<DEPTH -> store data_in lane i at wr_ptr[i], wr_ptr++ (wraps mod DEPTH).
//    push[i] when full -> word dropped, state unchanged.
//  - Read: pop[i] & count[i]>0 -> fifo_out<=mem[i][rd_ptr[i]], valid_out<=1, rd_ptr++ (wrap).
//    Latency 1: word visible the cycle after pop. No accepted pop -> fifo_out holds, valid_out<=0.
//  - pop[i] on empty lane: ignored, valid_out<=0, fifo_out holds.
//  - pop multi-hot (illegal): lowest-index set bit served; others ignored.
//  - Same lane push+pop, 0<count<DEPTH: both happen, count unchanged.
//    count==0: push accepted, pop ignored (no fall-through). count==DEPTH: pop accepted, push dropped.
//  - Lanes independent; any mix of lanes may push in the same cycle.
//  - Reset mid-operation discards all buffered words; post-reset first pop on any lane returns
//    nothing until a new push lands.
// CONFIGURATION
//  FIFO_ERR_EN defined: err[i] sets (sticky until reset) on push to full lane i, pop to empty
//    lane i, or pop multi-hot (all set pop bits flagged). Cleared only by reset.
//  FIFO_ERR_EN undefined: err tied 4'b0000; error logic absent; data behaviour identical.
// STRUCTURE
//  Package fifo_bank_pkg: N_LANES=4, DATA_W default, ptr/count widths ($clog2(DEPTH), +1),
//    lane index type, helper for lowest-set-bit select of pop.
//  Sub-module fifo_lane (x4 via generate): memory, wr/rd pointers, count, full/empty/almost_full,
//    pop-accept output and head word. Top: pop select, output mux + fifo_out/valid_out regs, err.
// TESTING
//  1. Reset with push=pop=0 -> empty=4'b1111, almost_full=0, fifo_out=0, valid_out=0.
//  2. Push 4 words 12'h296,12'h297,12'h298,12'h299 to P0, pop[0] x4 -> fifo_out same order, each 1
//     cycle after pop; empty[0]=1 after 4th pop.
//  3. Push 6 words to P2 -> almost_full[2]=1 the cycle after the 6th; 8 more pushes -> only 2 stored
//     (count 8); err[2]=1 under FIFO_ERR_EN, 0 otherwise.
//  4. P1 holds 1 word, push+pop P1 same cycle -> old word out, new word retained, count 1; repeat on
//     empty P3 -> push stored, valid_out=0.
//  5. pop=4'b0110 with P1,P2 non-empty -> P1 head returned, P2 untouched; err[1],err[2]=1 with macro.
//  6. Pointer wrap: 20 interleaved push/pop on P3 (DEPTH=8) -> output order exact; async reset
//     mid-stream -> flags to reset values same cycle, next pop valid_out=0.

Source files
------------

// File: rtl/fifo_bank_pkg.sv
// Shared constants, types and helpers for the four-lane ingress FIFO bank.
package fifo_bank_pkg;
  localparam int N_LANES   = 4;
  localparam int DATA_W    = 12;
  localparam int DEPTH     = 8;
  localparam int AF_LVL    = 6;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [$clog2(N_LANES)-1:0] lane_idx_t;

  // Keep only the lowest set bit of a pop request so an illegal multi-hot
  // request still serves exactly one lane.
  function automatic logic [N_LANES-1:0] lowest_set(input logic [N_LANES-1:0] v);
    logic [N_LANES-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/fifo_lane.sv
// One FIFO lane: storage, wrapping pointers, occupancy count and flags.
// Flags are decoded from the registered count only.
module fifo_lane
  import fifo_bank_pkg::*;
#(
  parameter int LANE_DATA_W = 12,
  parameter int LANE_DEPTH  = 8,
  parameter int LANE_AF_LVL = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [LANE_DATA_W-1:0] din,
  input  logic                   pop,
  output logic [LANE_DATA_W-1:0] head,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full
);
  localparam int LPTR_W = $clog2(LANE_DEPTH);
  localparam int LCNT_W = LPTR_W + 1;

  logic [LANE_DATA_W-1:0] mem [LANE_DEPTH];
  logic [LPTR_W-1:0]      wr_ptr;
  logic [LPTR_W-1:0]      rd_ptr;
  logic [LCNT_W-1:0]      count;

  assign empty       = (count == '0);
  assign full        = (count == LCNT_W'(LANE_DEPTH));
  assign almost_full = (count >= LCNT_W'(LANE_AF_LVL));
  // A pop on an empty lane is refused even if a push lands the same cycle.
  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign head        = mem[rd_ptr];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LPTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + LPTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LCNT_W'(1);
        2'b01:   count <= count - LCNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fifo_bank_in.sv
// Four-lane ingress FIFO bank with one muxed, registered read port.
// Optional sticky error flags are built only when FIFO_ERR_EN is defined.
//
// Read handshake: pop[i] is a request; it is accepted when it is the lowest
// set pop bit and lane i is non-empty. An accepted pop puts the head word on
// fifo_out with valid_out=1 one cycle later. Without an accepted pop valid_out
// drops to 0 and fifo_out keeps its last value. Writes have no back-pressure
// beyond almost_full: a push to a full lane is dropped.
module fifo_bank_in
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W = fifo_bank_pkg::DATA_W,
  parameter int DEPTH  = fifo_bank_pkg::DEPTH,
  parameter int AF_LVL = fifo_bank_pkg::AF_LVL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_LANES-1:0]        push,
  input  logic [N_LANES*DATA_W-1:0] data_in,
  input  logic [N_LANES-1:0]        pop,
  output logic [DATA_W-1:0]         fifo_out,
  output logic                      valid_out,
  output logic [N_LANES-1:0]        empty,
  output logic [N_LANES-1:0]        almost_full,
  output logic [N_LANES-1:0]        err
);
  logic [N_LANES-1:0] pop_sel;
  logic [N_LANES-1:0] pop_ok;
  logic [N_LANES-1:0] push_ok;
  logic [N_LANES-1:0] full;
  logic [DATA_W-1:0]  heads [N_LANES];
  logic [DATA_W-1:0]  rd_word;

  assign pop_sel = lowest_set(pop);

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    fifo_lane #(
      .LANE_DATA_W(DATA_W),
      .LANE_DEPTH (DEPTH),
      .LANE_AF_LVL(AF_LVL)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .push       (push[i]),
      .din        (data_in[i*DATA_W +: DATA_W]),
      .pop        (pop_sel[i]),
      .head       (heads[i]),
      .push_ok    (push_ok[i]),
      .pop_ok     (pop_ok[i]),
      .empty      (empty[i]),
      .full       (full[i]),
      .almost_full(almost_full[i])
    );
  end

  // Select the head of the single accepted lane (pop_ok is at most one-hot).
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (pop_ok[i]) rd_word = heads[i];
    end
  end

  // Registered read port: load on an accepted pop, otherwise hold the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |pop_ok;
      if (|pop_ok) fifo_out <= rd_word;
    end
  end

`ifdef FIFO_ERR_EN
  logic               multi_hot;
  logic [N_LANES-1:0] err_set;
  logic [N_LANES-1:0] err_q;

  assign multi_hot = (pop & (pop - N_LANES'(1))) != '0;
  assign err_set   = (push & full) | (pop & empty) | (multi_hot ? pop : '0);
  assign err       = err_q;

  // Sticky error capture; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_q | err_set;
  end
`else
  assign err = '0;
  logic unused_ok;
  assign unused_ok = ^push_ok ^ ^full;
`endif
endmodule

// File: tb/tb_fifo_bank_in.sv
// Directed self-checking bench for fifo_bank_in (default DATA_W=12, DEPTH=8, AF_LVL=6).
module tb_fifo_bank_in;
  localparam int W = 12;

  logic          clk;
  logic          reset;
  logic [3:0]    push;
  logic [4*W-1:0] data_in;
  logic [3:0]    pop;
  logic [W-1:0]  fifo_out;
  logic          valid_out;
  logic [3:0]    empty;
  logic [3:0]    almost_full;
  logic [3:0]    err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_err;
  logic [W-1:0] last_out;

  fifo_bank_in dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .fifo_out(fifo_out), .valid_out(valid_out), .empty(empty),
    .almost_full(almost_full), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] lane_word(input int lane, input logic [W-1:0] w);
    logic [4*W-1:0] r;
    r = '0;
    r[lane*W +: W] = w;
    return r;
  endfunction

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic [3:0] p, input logic [4*W-1:0] d, input logic [3:0] q);
    push = p; data_in = d; pop = q;
    @(posedge clk); #1;
    push = '0; data_in = '0; pop = '0;
  endtask

  task automatic expect_err();
`ifdef FIFO_ERR_EN
    chk("err", {28'd0, err}, {28'd0, exp_err});
`else
    chk("err", {28'd0, err}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; push = '0; pop = '0; data_in = '0; exp_err = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1. reset state
    chk("rst_empty", {28'd0, empty}, 32'hF);
    chk("rst_af", {28'd0, almost_full}, 32'h0);
    chk("rst_out", {20'd0, fifo_out}, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'h0);
    expect_err();

    // 2. P0 in-order four words
    for (int k = 0; k < 4; k++) cyc(4'b0001, lane_word(0, W'(12'h296 + k)), 4'b0000);
    chk("p0_nonempty", {31'd0, empty[0]}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, '0, 4'b0001);
      chk("p0_valid", {31'd0, valid_out}, 32'h1);
      chk("p0_data", {20'd0, fifo_out}, 32'h296 + k);
    end
    chk("p0_empty", {31'd0, empty[0]}, 32'h1);
    cyc(4'b0000, '0, 4'b0001);  // pop on empty lane
    exp_err[0] = 1'b1;
    chk("p0_empty_pop_valid", {31'd0, valid_out}, 32'h0);
    chk("p0_empty_pop_hold", {20'd0, fifo_out}, 32'h299);
    expect_err();

    // 3. P2 almost_full and overflow
    for (int k = 0; k < 6; k++) begin
      cyc(4'b0100, lane_word(2, W'(12'h300 + k)), 4'b0000);
      chk("p2_af", {31'd0, almost_full[2]}, (k == 5) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 8; k++) cyc(4'b0100, lane_word(2, W'(12'h400 + k)), 4'b0000);
    exp_err[2] = 1'b1;
    expect_err();
    exp_q = {12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h400, 12'h401};
    while (exp_q.size() > 0) begin
      cyc(4'b0000, '0, 4'b0100);
      chk("p2_drain_valid", {31'd0, valid_out}, 32'h1);
      chk("p2_drain_data", {20'd0, fifo_out}, {20'd0, exp_q.pop_front()});
    end
    chk("p2_empty", {31'd0, empty[2]}, 32'h1);
    chk("p2_af_clear", {31'd0, almost_full[2]}, 32'h0);

    // 4. same-lane push+pop
    cyc(4'b0010, lane_word(1, 12'h111), 4'b0000);
    cyc(4'b0010, lane_word(1, 12'h222), 4'b0010);
    chk("p1_pp_valid", {31'd0, valid_out}, 32'h1);
    chk("p1_pp_data", {20'd0, fifo_out}, 32'h111);
    chk("p1_pp_nonempty", {31'd0, empty[1]}, 32'h0);
    cyc(4'b1000, lane_word(3, 12'h333), 4'b1000);  // empty lane: no fall-through
    exp_err[3] = 1'b1;
    chk("p3_pp_valid", {31'd0, valid_out}, 32'h0);
    chk("p3_pp_hold", {20'd0, fifo_out}, 32'h111);
    chk("p3_pp_stored", {31'd0, empty[3]}, 32'h0);
    cyc(4'b0000, '0, 4'b1000);
    chk("p3_data", {20'd0, fifo_out}, 32'h333);
    chk("p3_empty", {31'd0, empty[3]}, 32'h1);

    // 5. multi-hot pop serves lowest lane
    cyc(4'b0100, lane_word(2, 12'h555), 4'b0000);
    cyc(4'b0000, '0, 4'b0110);
    exp_err[1] = 1'b1; exp_err[2] = 1'b1;
    chk("mh_valid", {31'd0, valid_out}, 32'h1);
    chk("mh_data", {20'd0, fifo_out}, 32'h222);
    chk("mh_empty", {28'd0, empty}, 32'hB);
    expect_err();
    cyc(4'b0000, '0, 4'b0100);
    chk("mh_p2_data", {20'd0, fifo_out}, 32'h555);

    // 6. pointer wrap on P3 with model queue
    exp_q.delete();
    last_out = 12'h555;
    for (int k = 0; k < 20; k++) begin
      logic       do_pop;
      logic       exp_v;
      do_pop = (k % 3) != 0;
      exp_v  = do_pop && (exp_q.size() > 0);
      if (exp_v) last_out = exp_q.pop_front();
      exp_q.push_back(W'(12'h600 + k));
      cyc(4'b1000, lane_word(3, W'(12'h600 + k)), do_pop ? 4'b1000 : 4'b0000);
      chk("wrap_valid", {31'd0, valid_out}, {31'd0, exp_v});
      chk("wrap_data", {20'd0, fifo_out}, {20'd0, last_out});
    end
    while (exp_q.size() > 0) begin
      cyc(4'b0000, '0, 4'b1000);
      chk("wrap_drain", {20'd0, fifo_out}, {20'd0, exp_q.pop_front()});
    end
    chk("wrap_empty", {31'd0, empty[3]}, 32'h1);

    // async reset mid-stream
    cyc(4'b1111, {12'h7A3, 12'h7A2, 12'h7A1, 12'h7A0}, 4'b0000);
    cyc(4'b0000, '0, 4'b0001);
    chk("pre_rst_valid", {31'd0, valid_out}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_empty", {28'd0, empty}, 32'hF);
    chk("async_valid", {31'd0, valid_out}, 32'h0);
    chk("async_out", {20'd0, fifo_out}, 32'h0);
    exp_err = '0;
    expect_err();
    @(posedge clk); #1 reset = 1'b0;
    cyc(4'b0000, '0, 4'b0010);
    chk("post_rst_pop", {31'd0, valid_out}, 32'h0);
    cyc(4'b0010, lane_word(1, 12'h0C5), 4'b0000);
    cyc(4'b0000, '0, 4'b0010);
    chk("post_rst_data", {20'd0, fifo_out}, 32'h0C5);
    chk("post_rst_valid", {31'd0, valid_out}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
